// File: rtl/decode_issue_stage.sv
// Decode/issue stage: operand read with writeback bypass, per-register
// pending-write scoreboard for RAW stalls, and a valid/ready register toward execute.
module decode_issue_stage #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned CNT_W    = 2
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [PC_W-1:0]   dec_pc,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic [ADDR_W-1:0] dec_rd,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic              dec_wr_rd,

    output logic [ADDR_W-1:0] src1_addr,
    output logic [ADDR_W-1:0] src2_addr,
    input  logic [DATA_W-1:0] reg1_data,
    input  logic [DATA_W-1:0] reg2_data,

    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,

    input  logic              flush,

    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [PC_W-1:0]   ex_pc,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_wr_rd,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    cnt [NUM_REGS];

    logic                wb_hit1;
    logic                wb_hit2;
    logic                wb_hit_rd;
    logic [DATA_W-1:0]   op1_sel;
    logic [DATA_W-1:0]   op2_sel;
    logic                haz_rs1;
    logic                haz_rs2;
    logic                haz_rd;
    logic                out_free;
    logic                issue;
    logic [NUM_REGS-1:0] cnt_inc;
    logic [NUM_REGS-1:0] cnt_dec;

    assign src1_addr = dec_rs1;
    assign src2_addr = dec_rs2;

    // Bypass: a writeback landing this cycle supersedes the pre-write file data.
    always_comb begin
        wb_hit1   = wb_en && (wb_addr == dec_rs1);
        wb_hit2   = wb_en && (wb_addr == dec_rs2);
        wb_hit_rd = wb_en && (wb_addr == dec_rd);
        op1_sel   = wb_hit1 ? wb_data : reg1_data;
        op2_sel   = wb_hit2 ? wb_data : reg2_data;
    end

    // A source is ready if nothing is pending, or only its last write lands now.
    always_comb begin
        haz_rs1 = dec_use_rs1 && (cnt[dec_rs1] != '0)
                  && !((cnt[dec_rs1] == CNT_ONE) && wb_hit1);
        haz_rs2 = dec_use_rs2 && (cnt[dec_rs2] != '0)
                  && !((cnt[dec_rs2] == CNT_ONE) && wb_hit2);
        haz_rd  = dec_wr_rd && (cnt[dec_rd] == CNT_MAX) && !wb_hit_rd;
    end

    always_comb begin
        out_free  = !ex_valid || ex_ready;
        dec_ready = dec_valid && !reset && !flush && out_free
                    && !haz_rs1 && !haz_rs2 && !haz_rd;
        issue     = dec_ready;
    end

    // Per-register increment/decrement requests; decrement saturates at zero.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_inc[r] = issue && dec_wr_rd && (dec_rd == ADDR_W'(r));
            cnt_dec[r] = wb_en && (wb_addr == ADDR_W'(r)) && (cnt[r] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (cnt_inc[r] && !cnt_dec[r]) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (cnt_dec[r] && !cnt_inc[r]) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Output register toward execute; payload holds whenever nothing new issues.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_rd    <= '0;
            ex_wr_rd <= 1'b0;
            ex_op1   <= '0;
            ex_op2   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (issue) begin
            ex_valid <= 1'b1;
            ex_pc    <= dec_pc;
            ex_rd    <= dec_rd;
            ex_wr_rd <= dec_wr_rd;
            ex_op1   <= op1_sel;
            ex_op2   <= op2_sel;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
